// File: rtl/ram_sync_clr.sv
// Parametrised single-port synchronous RAM with a registered read port,
// a one-cycle read-valid strobe and a hardware clear engine.
//
// After reset, and whenever a clear is requested, the engine sweeps every
// word to zero, one word per clock. While it does so, busy is high and all
// user requests are ignored. As a result, stale contents can never be read.

module ram_sync_clr #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = (1 << ADDR_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we,
    input  logic              re,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    // Extra address bit so DEPTH == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              last_clear;
    logic              do_write;
    logic              do_read;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // A user address can be anywhere in the ADDR_W space.
    // Words beyond DEPTH do not exist.
    assign in_range   = ({1'b0, addr} < DEPTH_EXT);
    assign busy       = (state == CLEAR);
    assign last_clear = busy && (clr_ptr == LAST_PTR);

    // A clear request takes priority over any access made in the same cycle
    assign do_write = !busy && !clr && we && in_range;
    assign do_read  = !busy && !clr && re;

    // State register: reset always restarts the sweep from the top
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave CLEAR on the edge that zeroes the last word
    always_comb begin
        state_next = state;
        case (state)
            CLEAR: begin
                if (last_clear) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Clear pointer: advance through the sweep, parked at zero otherwise.
    // Parking at zero means a newly accepted clear starts at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr <= '0;
        end else if (busy && !last_clear) begin
            clr_ptr <= clr_ptr + 1'b1;
        end else begin
            clr_ptr <= '0;
        end
    end

    // Write-port mux: the sweep owns the port while busy, the user otherwise
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = data_in;
        if (!rst) begin
            if (busy) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wdata = '0;
            end else if (do_write) begin
                mem_we = 1'b1;
            end
        end
    end

    // Storage array: no reset, so the clear engine is the only way to zero it
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read port.
    // Write-first on a simultaneous write, and zero for nonexistent words.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_read;
            if (do_read) begin
                if (!in_range) begin
                    data_out <= '0;
                end else if (we) begin
                    data_out <= data_in;
                end else begin
                    data_out <= mem[addr];
                end
            end
        end
    end

endmodule
